// File: rtl/eth_tx_framer.sv
// eth_tx_framer: RMII (one dibit per clock) Ethernet transmit framer.
// Sends preamble/SFD, the MAC header, a fixed-length payload pulled from an
// upstream dibit source, the CRC-32 FCS, and then holds the line idle for the
// inter-frame gap.
//
// Handshake: a source dibit transfers on a rising clk edge where axiiv=1 and
// stall=0. While stall=1 the source holds axiid/axiiv. stall is only low
// during the payload consumption window. If axiiv=0 inside that window, the
// framer still takes a dibit: it uses 00 and marks the frame bad.
//
// Optional build macro ETH_TX_CANCEL_EN adds the `cancelled` input. It aborts
// the frame in flight and jumps to the inter-frame gap.
//
// dbg_state exposes the FSM state. IDLE encodes as 0.
module eth_tx_framer #(
  parameter logic [47:0] DEST_MAC      = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC       = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          PAYLOAD_BYTES = 46,
  parameter int          IFG_CYCLES    = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
`ifdef ETH_TX_CANCEL_EN
  input  logic       cancelled,
`endif
  output logic       stall,
  output logic       phy_txen,
  output logic [1:0] phy_txd,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    FCS      = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [111:0] HDR            = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [31:0]  CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [15:0]  PRE_LAST       = 16'd31;
  localparam logic [15:0]  HDR_LAST       = 16'd55;
  localparam logic [15:0]  PREFETCH_FIRST = 16'd52;
  localparam logic [15:0]  PAY_LAST       = 16'(4 * PAYLOAD_BYTES - 1);
  localparam logic [15:0]  WIN_LAST       = 16'(4 * PAYLOAD_BYTES - 5);
  localparam logic [15:0]  FCS_LAST       = 16'd15;
  localparam logic [15:0]  IFG_LAST       = 16'(IFG_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] crc;
  logic        bad;
  logic [1:0]  col0, col1, col2;        // collecting d7d6, d5d4, d3d2 of the incoming byte
  logic [1:0]  hold76, hold54, hold32;  // previous byte, being replayed in wire order
  logic        txen_n;
  logic [1:0]  txd_n;
  logic [1:0]  in_dibit;
  logic        consume;
  logic        cancel_req;
  logic [6:0]  hdr_idx;
  logic [4:0]  fcs_idx;
  logic [31:0] fcs_word;

  // Reflected CRC-32: the dibit's bit 0 goes on the wire first, then bit 1.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

`ifdef ETH_TX_CANCEL_EN
  assign cancel_req = cancelled && (state != IDLE) && (state != GAP);
`else
  assign cancel_req = 1'b0;
`endif

  assign dbg_state = state;
  assign in_dibit  = axiiv ? axiid : 2'b00;
  assign consume   = !stall;

  // Open the consumption window for the last four header cycles (prefetch of
  // byte 0) through the payload cycle that takes the final dibit.
  always_comb begin
    stall = 1'b1;
    if (state == HEADER && cnt >= PREFETCH_FIRST) stall = 1'b0;
    if (state == PAYLOAD && cnt <= WIN_LAST)      stall = 1'b0;
    if (cancel_req)                               stall = 1'b1;
  end

  // Next-state and per-state cycle counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (axiiv) state_n = PREAMBLE;
      end
      PREAMBLE: if (cnt == PRE_LAST) begin state_n = HEADER;  cnt_n = '0; end
      HEADER:   if (cnt == HDR_LAST) begin state_n = PAYLOAD; cnt_n = '0; end
      PAYLOAD:  if (cnt == PAY_LAST) begin state_n = FCS;     cnt_n = '0; end
      FCS:      if (cnt == FCS_LAST) begin state_n = GAP;     cnt_n = '0; end
      GAP:      if (cnt == IFG_LAST) begin state_n = IDLE;    cnt_n = '0; end
      default:  begin state_n = IDLE; cnt_n = '0; end
    endcase
    if (cancel_req) begin
      state_n = GAP;
      cnt_n   = '0;
    end
  end

  // Select the dibit for the cycle being entered, so the registered pins
  // line up with the state register.
  always_comb begin
    txen_n   = 1'b0;
    txd_n    = 2'b00;
    hdr_idx  = 7'd104 - {cnt_n[5:2], 3'b000} + {4'b0000, cnt_n[1:0], 1'b0};
    fcs_idx  = {cnt_n[3:0], 1'b0};
    fcs_word = bad ? crc : ~crc;
    case (state_n)
      PREAMBLE: begin
        txen_n = 1'b1;
        txd_n  = (cnt_n == PRE_LAST) ? 2'b11 : 2'b01;
      end
      HEADER: begin
        txen_n = 1'b1;
        txd_n  = HDR[hdr_idx +: 2];
      end
      PAYLOAD: begin
        txen_n = 1'b1;
        case (cnt_n[1:0])
          2'd0:    txd_n = in_dibit;  // d1d0 goes straight out as it arrives
          2'd1:    txd_n = hold32;
          2'd2:    txd_n = hold54;
          default: txd_n = hold76;
        endcase
      end
      FCS: begin
        txen_n = 1'b1;
        txd_n  = fcs_word[fcs_idx +: 2];
      end
      default: ;
    endcase
  end

  // State, counter and registered PHY pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      phy_txen <= 1'b0;
      phy_txd  <= 2'b00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phy_txen <= txen_n;
      phy_txd  <= txd_n;
    end
  end

  // Running CRC over the header/payload dibits sent, plus the sticky underrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC_INIT;
      bad <= 1'b0;
    end else begin
      if (state_n == HEADER || state_n == PAYLOAD) crc <= crc_step(crc, txd_n);
      else if (state == GAP || state == IDLE)      crc <= CRC_INIT;
      if (state == GAP)              bad <= 1'b0;
      else if (consume && !axiiv)    bad <= 1'b1;
    end
  end

  // Double buffer: collect three dibits of a byte, then hand them to the hold
  // registers when the fourth arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col0 <= 2'b00; col1 <= 2'b00; col2 <= 2'b00;
      hold76 <= 2'b00; hold54 <= 2'b00; hold32 <= 2'b00;
    end else if (state == GAP) begin
      col0 <= 2'b00; col1 <= 2'b00; col2 <= 2'b00;
      hold76 <= 2'b00; hold54 <= 2'b00; hold32 <= 2'b00;
    end else if (consume) begin
      case (cnt[1:0])
        2'd0: col0 <= in_dibit;
        2'd1: col1 <= in_dibit;
        2'd2: col2 <= in_dibit;
        default: begin
          hold76 <= col0;
          hold54 <= col1;
          hold32 <= col2;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: randomized frames checked against a byte-level frame model.
module tb_eth_tx_framer;

  localparam int          PB   = 46;
  localparam int          IFG  = 48;
  localparam int          LEN  = 32 + 56 + 4 * PB + 16;
  localparam logic [47:0] DEST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC  = 48'h69_69_5A_06_54_91;
  localparam logic [15:0] ETYP = 16'h88B5;

  logic       clk = 1'b0;
  logic       rst;
  logic       axiiv;
  logic [1:0] axiid;
  logic       stall;
  logic       phy_txen;
  logic [1:0] phy_txd;
  logic [2:0] dbg_state;
`ifdef ETH_TX_CANCEL_EN
  logic       cancelled = 1'b0;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] pay [PB];
  logic [7:0] exp_q [$];
  logic [1:0] last_wire [$];

  eth_tx_framer dut (
    .clk       (clk),
    .rst       (rst),
    .axiiv     (axiiv),
    .axiid     (axiid),
`ifdef ETH_TX_CANCEL_EN
    .cancelled (cancelled),
`endif
    .stall     (stall),
    .phy_txen  (phy_txen),
    .phy_txd   (phy_txd),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31 - i];
    return r;
  endfunction

  // Source order: each payload byte goes out MSB dibit first.
  function automatic logic [1:0] src_dibit(input int k);
    logic [7:0] b;
    if (k >= 4 * PB) return 2'b00;
    b = pay[k / 4];
    return b[7 - 2 * (k % 4) -: 2];
  endfunction

  // Expected frame in bytes. A dropped dibit becomes 00, and the FCS is
  // inverted if any dibit was dropped.
  task automatic build_expected(input int drop_k);
    logic [7:0]   b;
    logic [31:0]  c;
    logic [111:0] hdr;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    hdr = {DEST, SRC, ETYP};
    for (int i = 0; i < 14; i++) exp_q.push_back(hdr[111 - 8 * i -: 8]);
    for (int i = 0; i < PB; i++) begin
      b = pay[i];
      if (drop_k >= 0 && drop_k / 4 == i) b[7 - 2 * (drop_k % 4) -: 2] = 2'b00;
      exp_q.push_back(b);
    end
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < exp_q.size(); i++) c = crc_byte(c, exp_q[i]);
    if (drop_k < 0) c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8 * i +: 8]);
  endtask

  // Driver + monitor for one frame. Call at a negedge. exp_low is the number
  // of txen-low cycles expected before the frame starts.
  task automatic send_frame(input string name, input int drop_k, input int exp_low);
    int          low, k, n_hi, n_sl, first_sl, gap_sl;
    logic [1:0]  wq [$];
    logic [7:0]  gq [$];
    logic [7:0]  got_b, exp_b;
    logic [31:0] res;
    low = 0; k = 0; n_hi = 0; n_sl = 0; first_sl = -1; gap_sl = 0;
    axiiv = 1'b1;
    axiid = src_dibit(0);
    while (!phy_txen && low < 500) begin
      if (!stall) gap_sl++;
      low++;
      @(negedge clk);
    end
    check({name, "_lead_low"}, low, exp_low);
    check({name, "_lead_stall"}, gap_sl, 0);
    if (low >= 500) return;
    for (int w = 0; w < LEN; w++) begin
      if (phy_txen) n_hi++;
      wq.push_back(phy_txd);
      if (!stall) begin
        if (first_sl < 0) first_sl = w;
        n_sl++;
        axiiv = (k != drop_k);
        axiid = src_dibit(k);
        k++;
      end else begin
        axiiv = 1'b1;
      end
      @(negedge clk);
    end
    check({name, "_txen_cycles"}, n_hi, LEN);
    check({name, "_txen_after"}, phy_txen, 0);
    check({name, "_win_start"}, first_sl, 84);
    check({name, "_win_len"}, n_sl, 4 * PB);
    build_expected(drop_k);
    for (int i = 0; i < LEN / 4; i++) begin
      got_b = {wq[4 * i + 3], wq[4 * i + 2], wq[4 * i + 1], wq[4 * i]};
      gq.push_back(got_b);
      exp_b = exp_q.pop_front();
      check($sformatf("%s_byte%0d", name, i), got_b, exp_b);
    end
    res = 32'hFFFF_FFFF;
    for (int i = 8; i < LEN / 4; i++) res = crc_byte(res, gq[i]);
    if (drop_k < 0) check({name, "_residue"}, rev32(res), 32'hC704_DD7B);
    else            check({name, "_residue_bad"}, rev32(res) == 32'hC704_DD7B, 0);
    last_wire = wq;
  endtask

  task automatic fill_random();
    for (int i = 0; i < PB; i++) pay[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic [1:0] ro_exp [8];
    int         n_hi, n_bad, n;
    ro_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11};

    // Reset and idle
    rst = 1'b0; axiiv = 1'b0; axiid = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_txen", phy_txen, 0);
    check("rst_txd", phy_txd, 0);
    check("rst_stall", stall, 1);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    n_hi = 0; n_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (phy_txen) n_hi++;
      if (!stall || phy_txd != 2'b00) n_bad++;
    end
    check("idle_txen", n_hi, 0);
    check("idle_stall_txd", n_bad, 0);

    // Reorder pattern in the first two payload bytes
    fill_random();
    pay[0] = 8'hAA;
    pay[1] = 8'hC0;
    send_frame("reorder", -1, 1);
    for (int i = 0; i < 8; i++) check($sformatf("reorder_wire%0d", i), last_wire[88 + i], ro_exp[i]);

    // All-0xAA frame sent back to back: gap cycles plus one IDLE sample
    for (int i = 0; i < PB; i++) pay[i] = 8'hAA;
    send_frame("allaa", -1, IFG + 1);

    fill_random();
    send_frame("underrun_mid", $urandom_range(8, 4 * PB - 9), IFG + 1);
    fill_random();
    send_frame("recover", -1, IFG + 1);
    fill_random();
    send_frame("underrun_first", 0, IFG + 1);
    fill_random();
    send_frame("underrun_last", 4 * PB - 1, IFG + 1);
    fill_random();
    send_frame("random", -1, IFG + 1);

    // Reset asserted mid-payload aborts at once
    axiiv = 1'b1; axiid = 2'b00;
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_window", n < 200, 1);
    repeat (10) @(negedge clk);
    check("abort_pre_txen", phy_txen, 1);
    rst = 1'b0;
    #1;
    check("abort_txen", phy_txen, 0);
    check("abort_txd", phy_txd, 0);
    check("abort_stall", stall, 1);
    axiiv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (phy_txen || !stall) n_hi++;
    end
    check("abort_quiet", n_hi, 0);
    fill_random();
    send_frame("post_reset", -1, 1);

    axiiv = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
